// File: rtl/sram_pkg.sv
// Shared types and widths for the dual-SRAM arbiter.
// Optional round-robin arbitration is enabled by SRAM_ARB_RR_EN.
package sram_pkg;

   localparam int SRAM_AW  = 20;
   localparam int SRAM_DW  = 32;
   localparam int SRAM_BEW = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } sram_state_e;

   typedef enum logic {
      OWN_INST,
      OWN_DATA
   } sram_owner_e;

endpackage

// File: rtl/sram_port_fsm.sv
// One SRAM's access sequencer: latches a grant, drives registered
// strobes for ACCESS_CYCLES cycles, then pulses the owner's ack.
module sram_port_fsm
   import sram_pkg::*;
#(
   parameter int ACCESS_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                grant,
   input  logic                grant_we,
   input  sram_owner_e         grant_own,
   input  logic [SRAM_AW-1:0]  grant_addr,
   input  logic [SRAM_BEW-1:0] grant_be,
   input  logic [SRAM_DW-1:0]  grant_wdata,
   output logic                idle,
   output logic [SRAM_AW-1:0]  ram_addr,
   output logic [SRAM_DW-1:0]  ram_wdata,
   input  logic [SRAM_DW-1:0]  ram_rdata,
   output logic                ram_data_oe,
   output logic                ram_ce_n,
   output logic                ram_oe_n,
   output logic                ram_we_n,
   output logic [SRAM_BEW-1:0] ram_be_n,
   output logic                ack_inst,
   output logic                ack_data,
   output logic [SRAM_DW-1:0]  rdata
);

   localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

   sram_state_e         state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                we_q, we_d;
   sram_owner_e         own_q, own_d;
   logic [SRAM_BEW-1:0] be_q, be_d;
   logic [SRAM_AW-1:0]  addr_d;
   logic [SRAM_DW-1:0]  wdata_d, rdata_d;
   logic                ack_inst_d, ack_data_d;
   logic                ce_n_d, oe_n_d, we_n_d, data_oe_d;
   logic [SRAM_BEW-1:0] be_n_d;
   logic                acc_d;

   assign idle = (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      own_d      = own_q;
      be_d       = be_q;
      addr_d     = ram_addr;
      wdata_d    = ram_wdata;
      rdata_d    = rdata;
      ack_inst_d = 1'b0;
      ack_data_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACCESS;
               cnt_d   = LAST;
               we_d    = grant_we;
               own_d   = grant_own;
               be_d    = grant_be;
               addr_d  = grant_addr;
               wdata_d = grant_wdata;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d    = DONE;
               ack_inst_d = (own_q == OWN_INST);
               ack_data_d = (own_q == OWN_DATA);
               if (!we_q) rdata_d = ram_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobes are registered, so derive them from the next state.
      acc_d     = (state_d == ACCESS);
      ce_n_d    = ~acc_d;
      oe_n_d    = ~(acc_d & ~we_d);
      data_oe_d = acc_d & we_d;
      we_n_d    = ~(acc_d & we_d & (cnt_d != '0));
      be_n_d    = {SRAM_BEW{1'b1}};
      if (acc_d) be_n_d = we_d ? ~be_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         own_q       <= OWN_INST;
         be_q        <= '0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_data_oe <= 1'b0;
         ram_ce_n    <= 1'b1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
         ram_be_n    <= {SRAM_BEW{1'b1}};
         ack_inst    <= 1'b0;
         ack_data    <= 1'b0;
         rdata       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         own_q       <= own_d;
         be_q        <= be_d;
         ram_addr    <= addr_d;
         ram_wdata   <= wdata_d;
         ram_data_oe <= data_oe_d;
         ram_ce_n    <= ce_n_d;
         ram_oe_n    <= oe_n_d;
         ram_we_n    <= we_n_d;
         ram_be_n    <= be_n_d;
         ack_inst    <= ack_inst_d;
         ack_data    <= ack_data_d;
         rdata       <= rdata_d;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Routes fetch and data requests to base_ram / ext_ram by addr[SEL_BIT].
// Define SRAM_ARB_RR_EN for per-SRAM round-robin instead of data priority.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ACCESS_CYCLES = 3,
   parameter int SEL_BIT       = 22
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [31:0]         inst_addr,
   output logic [31:0]         inst_rdata,
   output logic                inst_ack,
   input  logic                data_req,
   input  logic                data_we,
   input  logic [31:0]         data_addr,
   input  logic [3:0]          data_be,
   input  logic [31:0]         data_wdata,
   output logic [31:0]         data_rdata,
   output logic                data_ack,
   output logic [SRAM_AW-1:0]  base_ram_addr,
   output logic [SRAM_DW-1:0]  base_ram_wdata,
   input  logic [SRAM_DW-1:0]  base_ram_rdata,
   output logic                base_ram_data_oe,
   output logic                base_ram_ce_n,
   output logic                base_ram_oe_n,
   output logic                base_ram_we_n,
   output logic [SRAM_BEW-1:0] base_ram_be_n,
   output logic [SRAM_AW-1:0]  ext_ram_addr,
   output logic [SRAM_DW-1:0]  ext_ram_wdata,
   input  logic [SRAM_DW-1:0]  ext_ram_rdata,
   output logic                ext_ram_data_oe,
   output logic                ext_ram_ce_n,
   output logic                ext_ram_oe_n,
   output logic                ext_ram_we_n,
   output logic [SRAM_BEW-1:0] ext_ram_be_n
);

   logic base_inst, base_data, ext_inst, ext_data;
   logic base_pick, ext_pick;
   logic base_idle, ext_idle, base_grant, ext_grant;
   logic base_ack_i, base_ack_d, ext_ack_i, ext_ack_d;
   logic [SRAM_DW-1:0] base_rd, ext_rd;
   logic unused_addr_bits;

   assign base_inst = inst_req & ~inst_addr[SEL_BIT];
   assign base_data = data_req & ~data_addr[SEL_BIT];
   assign ext_inst  = inst_req &  inst_addr[SEL_BIT];
   assign ext_data  = data_req &  data_addr[SEL_BIT];

   assign base_grant = base_idle & (base_inst | base_data);
   assign ext_grant  = ext_idle  & (ext_inst  | ext_data);

`ifdef SRAM_ARB_RR_EN
   // Set after a data grant so the fetch port wins the next tie.
   logic base_pri_inst, ext_pri_inst;

   assign base_pick = base_data & ~(base_inst & base_pri_inst);
   assign ext_pick  = ext_data  & ~(ext_inst  & ext_pri_inst);

   always_ff @(posedge clk) begin
      if (rst) begin
         base_pri_inst <= 1'b0;
         ext_pri_inst  <= 1'b0;
      end else begin
         if (base_grant) base_pri_inst <= base_pick;
         if (ext_grant)  ext_pri_inst  <= ext_pick;
      end
   end
`else
   assign base_pick = base_data;
   assign ext_pick  = ext_data;
`endif

   sram_port_fsm #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_base (
      .clk         (clk),
      .rst         (rst),
      .grant       (base_grant),
      .grant_we    (base_pick & data_we),
      .grant_own   (base_pick ? OWN_DATA : OWN_INST),
      .grant_addr  (base_pick ? data_addr[SRAM_AW+1:2]
                              : inst_addr[SRAM_AW+1:2]),
      .grant_be    (base_pick ? data_be : {SRAM_BEW{1'b1}}),
      .grant_wdata (data_wdata),
      .idle        (base_idle),
      .ram_addr    (base_ram_addr),
      .ram_wdata   (base_ram_wdata),
      .ram_rdata   (base_ram_rdata),
      .ram_data_oe (base_ram_data_oe),
      .ram_ce_n    (base_ram_ce_n),
      .ram_oe_n    (base_ram_oe_n),
      .ram_we_n    (base_ram_we_n),
      .ram_be_n    (base_ram_be_n),
      .ack_inst    (base_ack_i),
      .ack_data    (base_ack_d),
      .rdata       (base_rd)
   );

   sram_port_fsm #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_ext (
      .clk         (clk),
      .rst         (rst),
      .grant       (ext_grant),
      .grant_we    (ext_pick & data_we),
      .grant_own   (ext_pick ? OWN_DATA : OWN_INST),
      .grant_addr  (ext_pick ? data_addr[SRAM_AW+1:2]
                             : inst_addr[SRAM_AW+1:2]),
      .grant_be    (ext_pick ? data_be : {SRAM_BEW{1'b1}}),
      .grant_wdata (data_wdata),
      .idle        (ext_idle),
      .ram_addr    (ext_ram_addr),
      .ram_wdata   (ext_ram_wdata),
      .ram_rdata   (ext_ram_rdata),
      .ram_data_oe (ext_ram_data_oe),
      .ram_ce_n    (ext_ram_ce_n),
      .ram_oe_n    (ext_ram_oe_n),
      .ram_we_n    (ext_ram_we_n),
      .ram_be_n    (ext_ram_be_n),
      .ack_inst    (ext_ack_i),
      .ack_data    (ext_ack_d),
      .rdata       (ext_rd)
   );

   assign inst_ack   = base_ack_i | ext_ack_i;
   assign data_ack   = base_ack_d | ext_ack_d;
   assign inst_rdata = ({SRAM_DW{base_ack_i}} & base_rd)
                     | ({SRAM_DW{ext_ack_i}}  & ext_rd);
   assign data_rdata = ({SRAM_DW{base_ack_d}} & base_rd)
                     | ({SRAM_DW{ext_ack_d}}  & ext_rd);

   assign unused_addr_bits = ^{inst_addr, data_addr};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an ack scoreboard per port.
// Contention order follows SRAM_ARB_RR_EN when it is defined.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, data_req, data_we;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_be;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_ack, data_ack;
   logic [19:0] base_ram_addr, ext_ram_addr;
   logic [31:0] base_ram_wdata, ext_ram_wdata;
   logic [31:0] base_ram_rdata, ext_ram_rdata;
   logic        base_ram_data_oe, base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
   logic        ext_ram_data_oe, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
   logic [3:0]  base_ram_be_n, ext_ram_be_n;

   typedef struct {
      int          cyc;
      logic [31:0] rd;
      bit          chk;
   } exp_t;

   exp_t q_inst[$];
   exp_t q_data[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   sram_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .inst_req         (inst_req),
      .inst_addr        (inst_addr),
      .inst_rdata       (inst_rdata),
      .inst_ack         (inst_ack),
      .data_req         (data_req),
      .data_we          (data_we),
      .data_addr        (data_addr),
      .data_be          (data_be),
      .data_wdata       (data_wdata),
      .data_rdata       (data_rdata),
      .data_ack         (data_ack),
      .base_ram_addr    (base_ram_addr),
      .base_ram_wdata   (base_ram_wdata),
      .base_ram_rdata   (base_ram_rdata),
      .base_ram_data_oe (base_ram_data_oe),
      .base_ram_ce_n    (base_ram_ce_n),
      .base_ram_oe_n    (base_ram_oe_n),
      .base_ram_we_n    (base_ram_we_n),
      .base_ram_be_n    (base_ram_be_n),
      .ext_ram_addr     (ext_ram_addr),
      .ext_ram_wdata    (ext_ram_wdata),
      .ext_ram_rdata    (ext_ram_rdata),
      .ext_ram_data_oe  (ext_ram_data_oe),
      .ext_ram_ce_n     (ext_ram_ce_n),
      .ext_ram_oe_n     (ext_ram_oe_n),
      .ext_ram_we_n     (ext_ram_we_n),
      .ext_ram_be_n     (ext_ram_be_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (inst_ack === 1'b1) begin
         if (q_inst.size() == 0) begin
            check("inst_ack_unexpected", 1, 0);
         end else begin
            e = q_inst.pop_front();
            check("inst_ack_cycle", 64'(cyc), 64'(e.cyc));
            if (e.chk) check("inst_rdata", inst_rdata, e.rd);
         end
      end
      if (data_ack === 1'b1) begin
         if (q_data.size() == 0) begin
            check("data_ack_unexpected", 1, 0);
         end else begin
            e = q_data.pop_front();
            check("data_ack_cycle", 64'(cyc), 64'(e.cyc));
            if (e.chk) check("data_rdata", data_rdata, e.rd);
         end
      end
   end

   // Drop each req in its ack cycle; optionally change base pad data.
   task automatic wait_drop(input string name, input logic [31:0] pad2);
      for (int i = 0; i < 20 && (inst_req || data_req); i++) begin
         @(negedge clk);
         if (inst_ack === 1'b1) begin
            inst_req = 1'b0;
            base_ram_rdata = pad2;
         end
         if (data_ack === 1'b1) begin
            data_req = 1'b0;
            base_ram_rdata = pad2;
         end
      end
      check(name, {inst_req, data_req}, 2'b00);
   endtask

   task automatic single_read(input bit is_data, input logic [31:0] addr,
                              input logic [31:0] pad);
      @(negedge clk);
      if (addr[22]) ext_ram_rdata = pad;
      else base_ram_rdata = pad;
      if (is_data) begin
         data_req = 1'b1; data_we = 1'b0; data_addr = addr;
         q_data.push_back('{cyc + 4, pad, 1'b1});
      end else begin
         inst_req = 1'b1; inst_addr = addr;
         q_inst.push_back('{cyc + 4, pad, 1'b1});
      end
      wait_drop("single_timeout", pad);
   endtask

   task automatic contend(input bit data_first, input logic [31:0] r1,
                          input logic [31:0] r2);
      @(negedge clk);
      base_ram_rdata = r1;
      inst_req = 1'b1; inst_addr = 32'h8000_0020;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8000_0030;
      if (data_first) begin
         q_data.push_back('{cyc + 4, r1, 1'b1});
         q_inst.push_back('{cyc + 9, r2, 1'b1});
      end else begin
         q_inst.push_back('{cyc + 4, r1, 1'b1});
         q_data.push_back('{cyc + 9, r2, 1'b1});
      end
      wait_drop("contend_timeout", r2);
   endtask

   initial begin
      int lows;
      int acks;
      rst = 1'b1;
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_we = 0; data_addr = 0;
      data_be = 0; data_wdata = 0;
      base_ram_rdata = 0; ext_ram_rdata = 0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_base_strb",
            {base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
             base_ram_be_n, base_ram_data_oe}, 8'hFE);
      check("rst_ext_strb",
            {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n,
             ext_ram_be_n, ext_ram_data_oe}, 8'hFE);
      check("rst_addr", {base_ram_addr, ext_ram_addr}, 0);
      check("rst_wdata", {base_ram_wdata, ext_ram_wdata}, 0);
      check("rst_acks", {inst_ack, data_ack}, 0);
      check("rst_rdata", {inst_rdata, data_rdata}, 0);
      rst = 1'b0;
      @(negedge clk);

      // single read on base
      base_ram_rdata = 32'h1234_5678;
      inst_req = 1'b1; inst_addr = 32'h8000_0010;
      q_inst.push_back('{cyc + 4, 32'h1234_5678, 1'b1});
      lows = 0;
      repeat (3) begin
         @(negedge clk);
         if (!base_ram_ce_n && !base_ram_oe_n) lows++;
      end
      check("rd_addr", base_ram_addr, 20'h00004);
      check("rd_be_n", base_ram_be_n, 4'b0000);
      check("rd_strobe_cycles", lows, 3);
      wait_drop("rd_timeout", 32'h1234_5678);
      check("rd_done_ce_n", base_ram_ce_n, 1'b1);

      // byte write on ext
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h8040_0008;
      data_be = 4'b0010; data_wdata = 32'hAABB_CCDD;
      q_data.push_back('{cyc + 4, 32'h0, 1'b0});
      @(negedge clk);
      check("wr_addr", ext_ram_addr, 20'h00002);
      check("wr_be_n", ext_ram_be_n, 4'b1101);
      check("wr_wdata", ext_ram_wdata, 32'hAABB_CCDD);
      check("wr_c1", {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n,
                      ext_ram_data_oe}, 4'b0101);
      @(negedge clk);
      check("wr_c2_we_n", {ext_ram_ce_n, ext_ram_we_n}, 2'b00);
      @(negedge clk);
      check("wr_c3_hold", {ext_ram_ce_n, ext_ram_we_n}, 2'b01);
      wait_drop("wr_timeout", 32'h0);
      check("wr_done_oe", {ext_ram_ce_n, ext_ram_data_oe}, 2'b10);
      data_we = 1'b0;

      // parallel reads on both SRAMs
      @(negedge clk);
      base_ram_rdata = 32'h1111_0000; ext_ram_rdata = 32'h2222_0000;
      inst_req = 1'b1; inst_addr = 32'h8000_0000;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8040_0000;
      q_inst.push_back('{cyc + 4, 32'h1111_0000, 1'b1});
      q_data.push_back('{cyc + 4, 32'h2222_0000, 1'b1});
      wait_drop("par_timeout", 32'h1111_0000);

      // contention on base, priority state favours data in both builds
      contend(1'b1, 32'h3333_4444, 32'h5555_6666);

      // a data grant, then contention: round-robin serves inst first
      single_read(1'b1, 32'h8000_0040, 32'h7777_8888);
`ifdef SRAM_ARB_RR_EN
      contend(1'b0, 32'h9999_AAAA, 32'hBBBB_CCCC);
`else
      contend(1'b1, 32'h9999_AAAA, 32'hBBBB_CCCC);
`endif

      // reset in cycle 2 of a write
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h8040_0010;
      data_be = 4'hF; data_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; data_req = 1'b0; data_we = 1'b0;
      @(negedge clk);
      check("rst_mid_strb", {ext_ram_we_n, ext_ram_ce_n,
                             ext_ram_data_oe}, 3'b110);
      rst = 1'b0;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (data_ack === 1'b1 || inst_ack === 1'b1) acks++;
      end
      check("rst_mid_no_ack", acks, 0);

      // back-to-back data reads with req held through the ack
      @(negedge clk);
      base_ram_rdata = 32'h0000_00A1;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8000_0100;
      q_data.push_back('{cyc + 4, 32'h0000_00A1, 1'b1});
      q_data.push_back('{cyc + 9, 32'h0000_00B2, 1'b1});
      repeat (4) @(negedge clk);
      check("b2b_ack1", data_ack, 1'b1);
      check("b2b_done_ce_n", {base_ram_ce_n, base_ram_oe_n}, 2'b11);
      data_addr = 32'h8000_0104;
      base_ram_rdata = 32'h0000_00B2;
      @(negedge clk);
      check("b2b_idle_ce_n", base_ram_ce_n, 1'b1);
      @(negedge clk);
      check("b2b_second_start", {base_ram_ce_n, base_ram_addr},
            {1'b0, 20'h00041});
      wait_drop("b2b_timeout", 32'h0000_00B2);

      repeat (5) @(negedge clk);
      check("inst_q_empty", q_inst.size(), 0);
      check("data_q_empty", q_data.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
